// File: rtl/mesi_emitter_array.sv
// MESI line-state controller for a direct-mapped cache. CPU events come in over valid/ready,
// bus transactions go out over req/gnt, and remote snoops are applied every cycle.
module mesi_emitter_array #(
    parameter int IDX_W = 2
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             cpu_valid,
    output logic             cpu_ready,
    input  logic [IDX_W-1:0] cpu_idx,
    input  logic [4:0]       CPU_event,
    output logic             bus_req,
    output logic [1:0]       bus_cmd,
    output logic [IDX_W-1:0] bus_idx,
    input  logic             bus_gnt,
    input  logic             snoop_valid,
    input  logic [IDX_W-1:0] snoop_idx,
    input  logic             snoop_cmd,
    output logic             snoop_wb,
    output logic             done,
    output logic             err,
    input  logic [IDX_W-1:0] state_idx,
    output logic [2:0]       state
);

    localparam int N_LINES = 2 ** IDX_W;

    localparam logic [2:0] ST_I = 3'b001;
    localparam logic [2:0] ST_S = 3'b010;
    localparam logic [2:0] ST_E = 3'b011;
    localparam logic [2:0] ST_M = 3'b100;

    localparam logic [1:0] CMD_RD   = 2'b00;
    localparam logic [1:0] CMD_RDX  = 2'b01;
    localparam logic [1:0] CMD_UPGR = 2'b10;
    localparam logic [1:0] CMD_WB   = 2'b11;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_WB   = 2'd1,
        FSM_REQ  = 2'd2
    } fsm_t;

    fsm_t             r_fsm;
    fsm_t             w_fsm_next;
    logic [2:0]       r_line [N_LINES];
    logic [2:0]       w_snp_next [N_LINES];
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_cmd;
    logic [2:0]       r_final;
    logic             r_done;
    logic             r_err;
    logic             r_snoop_wb;

    logic             w_accept;
    logic [2:0]       w_cur;
    logic             w_legal;
    logic             w_silent;
    logic             w_silent_wr;
    logic             w_need_wb;
    logic [1:0]       w_bus_cmd;
    logic [2:0]       w_final;
    logic             w_bus_ev;
    logic             w_gnt;
    logic             w_snp_hit;
    logic             w_cpu_wr;
    logic [IDX_W-1:0] w_cpu_idx;
    logic [2:0]       w_cpu_val;

    assign w_accept  = (r_fsm == FSM_IDLE) && cpu_valid;
    assign w_cur     = r_line[cpu_idx];
    assign w_gnt     = bus_gnt && bus_req;
    assign w_snp_hit = snoop_valid && (snoop_idx == r_idx);
    assign w_bus_ev  = w_legal && !w_silent;

    // Classify the incoming event against the line's current state.
    always_comb begin
        w_legal     = (CPU_event[3:0] != 4'd0) &&
                      ((CPU_event[3:0] & (CPU_event[3:0] - 4'd1)) == 4'd0);
        w_silent    = 1'b0;
        w_silent_wr = 1'b0;
        w_need_wb   = 1'b0;
        w_bus_cmd   = CMD_RD;
        w_final     = ST_I;
        if (w_legal) begin
            if (CPU_event[1] && (w_cur != ST_I)) begin
                w_silent = 1'b1;
            end else if (CPU_event[3] && (w_cur == ST_E)) begin
                w_silent    = 1'b1;
                w_silent_wr = 1'b1;
            end else if (CPU_event[3] && (w_cur == ST_M)) begin
                w_silent = 1'b1;
            end else if (CPU_event[3] && (w_cur == ST_S)) begin
                w_bus_cmd = CMD_UPGR;
                w_final   = ST_M;
            end else if (CPU_event[1] || CPU_event[0]) begin
                w_need_wb = (w_cur == ST_M);
                w_bus_cmd = CMD_RD;
                w_final   = CPU_event[4] ? ST_S : ST_E;
            end else begin
                w_need_wb = (w_cur == ST_M);
                w_bus_cmd = CMD_RDX;
                w_final   = ST_M;
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_fsm <= FSM_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // A snoop that touches the line being written back already flushed it, so the WB is skipped.
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            FSM_IDLE: begin
                if (w_accept && w_bus_ev) begin
                    w_fsm_next = w_need_wb ? FSM_WB : FSM_REQ;
                end
            end
            FSM_WB: begin
                if (w_gnt || w_snp_hit) begin
                    w_fsm_next = FSM_REQ;
                end
            end
            FSM_REQ: begin
                if (w_gnt) begin
                    w_fsm_next = FSM_IDLE;
                end
            end
            default: w_fsm_next = FSM_IDLE;
        endcase
    end

    always_comb begin
        cpu_ready = 1'b0;
        bus_req   = 1'b0;
        bus_cmd   = 2'b00;
        bus_idx   = '0;
        case (r_fsm)
            FSM_IDLE: cpu_ready = 1'b1;
            FSM_WB: begin
                bus_req = 1'b1;
                bus_cmd = CMD_WB;
                bus_idx = r_idx;
            end
            FSM_REQ: begin
                bus_req = 1'b1;
                bus_cmd = r_cmd;
                bus_idx = r_idx;
            end
            default: cpu_ready = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_idx      <= '0;
            r_cmd      <= CMD_RD;
            r_final    <= ST_I;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_snoop_wb <= 1'b0;
        end else begin
            r_done     <= (w_accept && w_legal && w_silent) || ((r_fsm == FSM_REQ) && w_gnt);
            r_err      <= w_accept && !w_legal;
            r_snoop_wb <= snoop_valid && (r_line[snoop_idx] == ST_M);
            if (w_accept && w_bus_ev) begin
                r_idx   <= cpu_idx;
                r_cmd   <= w_bus_cmd;
                r_final <= w_final;
            end else if ((r_fsm == FSM_REQ) && (r_cmd == CMD_UPGR) && w_snp_hit &&
                         snoop_cmd && !w_gnt) begin
                // Our shared copy was invalidated: the upgrade must now fetch the line.
                r_cmd <= CMD_RDX;
            end
        end
    end

    // CPU-side line writes come either from a silent E->M or from the final grant.
    assign w_cpu_wr  = (w_accept && w_silent_wr) || ((r_fsm == FSM_REQ) && w_gnt);
    assign w_cpu_idx = w_accept ? cpu_idx : r_idx;
    assign w_cpu_val = w_accept ? ST_M : r_final;

    genvar gi;
    generate
        for (gi = 0; gi < N_LINES; gi++) begin : g_line
            always_comb begin
                w_snp_next[gi] = r_line[gi];
                if (snoop_valid && (snoop_idx == IDX_W'(gi))) begin
                    if (snoop_cmd) begin
                        w_snp_next[gi] = ST_I;
                    end else if ((r_line[gi] == ST_M) || (r_line[gi] == ST_E)) begin
                        w_snp_next[gi] = ST_S;
                    end
                end
            end

            // CPU write takes priority over a same-edge snoop on the same line.
            always_ff @(posedge CLK or posedge CLR) begin
                if (CLR) begin
                    r_line[gi] <= ST_I;
                end else if (w_cpu_wr && (w_cpu_idx == IDX_W'(gi))) begin
                    r_line[gi] <= w_cpu_val;
                end else begin
                    r_line[gi] <= w_snp_next[gi];
                end
            end
        end
    endgenerate

    assign state    = r_line[state_idx];
    assign done     = r_done;
    assign err      = r_err;
    assign snoop_wb = r_snoop_wb;

endmodule

// File: tb/tb_mesi_emitter_array.sv
// Directed bench for mesi_emitter_array: a vector table for the main flows plus
// hand-written reset sequences.
module tb_mesi_emitter_array;

    logic       CLK;
    logic       CLR;
    logic       cpu_valid;
    logic       cpu_ready;
    logic [1:0] cpu_idx;
    logic [4:0] CPU_event;
    logic       bus_req;
    logic [1:0] bus_cmd;
    logic [1:0] bus_idx;
    logic       bus_gnt;
    logic       snoop_valid;
    logic [1:0] snoop_idx;
    logic       snoop_cmd;
    logic       snoop_wb;
    logic       done;
    logic       err;
    logic [1:0] state_idx;
    logic [2:0] state;

    mesi_emitter_array #(.IDX_W(2)) dut (
        .CLK         (CLK),
        .CLR         (CLR),
        .cpu_valid   (cpu_valid),
        .cpu_ready   (cpu_ready),
        .cpu_idx     (cpu_idx),
        .CPU_event   (CPU_event),
        .bus_req     (bus_req),
        .bus_cmd     (bus_cmd),
        .bus_idx     (bus_idx),
        .bus_gnt     (bus_gnt),
        .snoop_valid (snoop_valid),
        .snoop_idx   (snoop_idx),
        .snoop_cmd   (snoop_cmd),
        .snoop_wb    (snoop_wb),
        .done        (done),
        .err         (err),
        .state_idx   (state_idx),
        .state       (state)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       cv;
        logic [1:0] cidx;
        logic [4:0] ev;
        logic       sv;
        logic [1:0] sidx;
        logic       scmd;
        logic       gnt;
        logic [1:0] q;
        logic       e_rdy;
        logic       e_req;
        logic [1:0] e_cmd;
        logic [1:0] e_bidx;
        logic       e_done;
        logic       e_err;
        logic       e_swb;
        logic [2:0] e_st;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d got %0h want %0h", name, row, act, exp);
        end
    endtask

    task automatic addv(input logic cv, input logic [1:0] cidx, input logic [4:0] ev,
                        input logic sv, input logic [1:0] sidx, input logic scmd,
                        input logic gnt, input logic [1:0] q,
                        input logic e_rdy, input logic e_req, input logic [1:0] e_cmd,
                        input logic [1:0] e_bidx, input logic e_done, input logic e_err,
                        input logic e_swb, input logic [2:0] e_st);
        vec_t v;
        v.cv = cv; v.cidx = cidx; v.ev = ev; v.sv = sv; v.sidx = sidx; v.scmd = scmd;
        v.gnt = gnt; v.q = q; v.e_rdy = e_rdy; v.e_req = e_req; v.e_cmd = e_cmd;
        v.e_bidx = e_bidx; v.e_done = e_done; v.e_err = e_err; v.e_swb = e_swb;
        v.e_st = e_st;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        cpu_valid   = 1'b0;
        cpu_idx     = 2'd0;
        CPU_event   = 5'd0;
        bus_gnt     = 1'b0;
        snoop_valid = 1'b0;
        snoop_idx   = 2'd0;
        snoop_cmd   = 1'b0;
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        // rm idx1 sh=0, zero-wait grant; then wh hit on E
        addv(1, 1, 5'b00001, 0, 0, 0, 0, 1,  0, 1, 2'b00, 1,  0, 0, 0, 3'b001);
        addv(0, 0, 5'b00000, 0, 0, 0, 1, 1,  1, 0, 2'b00, 0,  1, 0, 0, 3'b011);
        addv(0, 0, 5'b00000, 0, 0, 0, 0, 1,  1, 0, 2'b00, 0,  0, 0, 0, 3'b011);
        addv(1, 1, 5'b01000, 0, 0, 0, 0, 1,  1, 0, 2'b00, 0,  1, 0, 0, 3'b100);
        // wm idx2 from I, then wm on M with a 3-cycle grant stall during WB
        addv(1, 2, 5'b00100, 0, 0, 0, 0, 2,  0, 1, 2'b01, 2,  0, 0, 0, 3'b001);
        addv(0, 0, 5'b00000, 0, 0, 0, 1, 2,  1, 0, 2'b00, 0,  1, 0, 0, 3'b100);
        addv(1, 2, 5'b00100, 0, 0, 0, 0, 2,  0, 1, 2'b11, 2,  0, 0, 0, 3'b100);
        addv(0, 0, 5'b00000, 0, 0, 0, 0, 2,  0, 1, 2'b11, 2,  0, 0, 0, 3'b100);
        addv(0, 0, 5'b00000, 0, 0, 0, 0, 2,  0, 1, 2'b11, 2,  0, 0, 0, 3'b100);
        addv(0, 0, 5'b00000, 0, 0, 0, 0, 2,  0, 1, 2'b11, 2,  0, 0, 0, 3'b100);
        addv(0, 0, 5'b00000, 0, 0, 0, 1, 2,  0, 1, 2'b01, 2,  0, 0, 0, 3'b100);
        addv(0, 0, 5'b00000, 0, 0, 0, 1, 2,  1, 0, 2'b00, 0,  1, 0, 0, 3'b100);
        addv(0, 0, 5'b00000, 0, 0, 0, 0, 2,  1, 0, 2'b00, 0,  0, 0, 0, 3'b100);
        // rm idx0 sh=1 -> S; wh on S upgrades, snoop invalidate turns it into BusRdX
        addv(1, 0, 5'b10001, 0, 0, 0, 0, 0,  0, 1, 2'b00, 0,  0, 0, 0, 3'b001);
        addv(0, 0, 5'b00000, 0, 0, 0, 1, 0,  1, 0, 2'b00, 0,  1, 0, 0, 3'b010);
        addv(1, 0, 5'b01000, 0, 0, 0, 0, 0,  0, 1, 2'b10, 0,  0, 0, 0, 3'b010);
        addv(0, 0, 5'b00000, 1, 0, 1, 0, 0,  0, 1, 2'b01, 0,  0, 0, 0, 3'b001);
        addv(0, 0, 5'b00000, 0, 0, 0, 1, 0,  1, 0, 2'b00, 0,  1, 0, 0, 3'b100);
        // snoop read on M line, then illegal event; stray gnt while idle
        addv(0, 0, 5'b00000, 1, 1, 0, 0, 1,  1, 0, 2'b00, 0,  0, 0, 1, 3'b010);
        addv(0, 0, 5'b00000, 0, 0, 0, 0, 1,  1, 0, 2'b00, 0,  0, 0, 0, 3'b010);
        addv(1, 1, 5'b00011, 0, 0, 0, 0, 1,  1, 0, 2'b00, 0,  0, 1, 0, 3'b010);
        addv(0, 0, 5'b00000, 0, 0, 0, 1, 2,  1, 0, 2'b00, 0,  0, 0, 0, 3'b100);
        // rm on M idx2: snoop downgrade during WB drops the writeback
        addv(1, 2, 5'b00001, 0, 0, 0, 0, 2,  0, 1, 2'b11, 2,  0, 0, 0, 3'b100);
        addv(0, 0, 5'b00000, 1, 2, 0, 0, 2,  0, 1, 2'b00, 2,  0, 0, 1, 3'b010);
        addv(0, 0, 5'b00000, 0, 0, 0, 1, 2,  1, 0, 2'b00, 0,  1, 0, 0, 3'b011);
        // wm idx3: final grant and invalidating snoop on the same edge
        addv(1, 3, 5'b00100, 0, 0, 0, 0, 3,  0, 1, 2'b01, 3,  0, 0, 0, 3'b001);
        addv(0, 0, 5'b00000, 1, 3, 1, 1, 3,  1, 0, 2'b00, 0,  1, 0, 0, 3'b100);
        addv(0, 0, 5'b00000, 0, 0, 0, 0, 3,  1, 0, 2'b00, 0,  0, 0, 0, 3'b100);

        CLR = 1'b1;
        idle_inputs();
        state_idx = 2'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        CLR = 1'b0;
        for (int q = 0; q < 4; q++) begin
            state_idx = 2'(q);
            #1;
            chk("reset_state", q, 32'(state), 32'(3'b001));
        end
        chk("reset_ready", 0, 32'(cpu_ready), 32'd1);
        chk("reset_req", 0, 32'(bus_req), 32'd0);
        chk("reset_cmd", 0, 32'(bus_cmd), 32'd0);
        chk("reset_bidx", 0, 32'(bus_idx), 32'd0);
        chk("reset_done", 0, 32'(done), 32'd0);
        chk("reset_err", 0, 32'(err), 32'd0);
        chk("reset_swb", 0, 32'(snoop_wb), 32'd0);
        @(negedge CLK);

        for (int i = 0; i < vecs.size(); i++) begin
            cpu_valid   = vecs[i].cv;
            cpu_idx     = vecs[i].cidx;
            CPU_event   = vecs[i].ev;
            snoop_valid = vecs[i].sv;
            snoop_idx   = vecs[i].sidx;
            snoop_cmd   = vecs[i].scmd;
            bus_gnt     = vecs[i].gnt;
            state_idx   = vecs[i].q;
            @(posedge CLK);
            @(negedge CLK);
            $display("row %0d: ready=%0b req=%0b cmd=%0b idx=%0d done=%0b err=%0b swb=%0b state=%b",
                     i, cpu_ready, bus_req, bus_cmd, bus_idx, done, err, snoop_wb, state);
            chk("ready", i, 32'(cpu_ready), 32'(vecs[i].e_rdy));
            chk("bus_req", i, 32'(bus_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) begin
                chk("bus_cmd", i, 32'(bus_cmd), 32'(vecs[i].e_cmd));
                chk("bus_idx", i, 32'(bus_idx), 32'(vecs[i].e_bidx));
            end
            chk("done", i, 32'(done), 32'(vecs[i].e_done));
            chk("err", i, 32'(err), 32'(vecs[i].e_err));
            chk("snoop_wb", i, 32'(snoop_wb), 32'(vecs[i].e_swb));
            chk("state", i, 32'(state), 32'(vecs[i].e_st));
        end
        idle_inputs();

        // Reset asserted mid-transaction must drop bus_req without waiting for a clock.
        cpu_valid = 1'b1;
        cpu_idx   = 2'd1;
        CPU_event = 5'b00100;
        @(posedge CLK);
        @(negedge CLK);
        cpu_valid = 1'b0;
        chk("pre_clr_req", 100, 32'(bus_req), 32'd1);
        chk("pre_clr_cmd", 100, 32'(bus_cmd), 32'(2'b01));
        #2;
        CLR = 1'b1;
        #1;
        chk("clr_req", 101, 32'(bus_req), 32'd0);
        chk("clr_ready", 101, 32'(cpu_ready), 32'd1);
        for (int q = 0; q < 4; q++) begin
            state_idx = 2'(q);
            #1;
            chk("clr_state", 101, 32'(state), 32'(3'b001));
        end
        @(negedge CLK);
        CLR = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        $display("post-reset: ready=%0b req=%0b done=%0b", cpu_ready, bus_req, done);
        chk("post_ready", 102, 32'(cpu_ready), 32'd1);
        chk("post_req", 102, 32'(bus_req), 32'd0);
        chk("post_done", 102, 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
